// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: decoder opcodes, register index width
// and the hazard controller state encoding.
package cpu_pkg;

    localparam int REG_W = 5;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } hazState_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard/stall controller: load-use bubbles, cache-miss freeze,
// deferred branch flush, miss watchdog. Option: BRANCH_ID_HAZARD_EN.
module hazard_stall_unit
    import cpu_pkg::*;
#(
    parameter int MISS_TIMEOUT = 1023,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ID_Rs1_i,
    input  logic [REG_W-1:0] ID_Rs2_i,
    input  logic             ID_Branch_i,
    input  logic             Branch_taken_i,
    input  logic             EX_MemRead_i,
    input  logic             EX_RegWrite_i,
    input  logic [REG_W-1:0] EX_Rd_i,
    input  logic             MEM_MemRead_i,
    input  logic [REG_W-1:0] MEM_Rd_i,
    input  logic             mem_stall_i,
    output logic             NoOp_o,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             Pipe_Stall_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] lu_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int TW = $clog2(MISS_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(MISS_TIMEOUT);

    hazState_e state, stateNext;
    logic flushPending, flushPendingNext;
    logic [TW-1:0] missTimer, missTimerNext;
    logic timeoutNext;
    logic lu, exLoadHit;
    logic luInc, missInc, flushInc;

    assign exLoadHit = EX_MemRead_i && EX_Rd_i != '0 &&
                       (EX_Rd_i == ID_Rs1_i || EX_Rd_i == ID_Rs2_i);

`ifdef BRANCH_ID_HAZARD_EN
    // beq compares in ID, so its operands cannot come from EX or a MEM load
    logic exWrHit, memLoadHit;

    assign exWrHit = EX_RegWrite_i && EX_Rd_i != '0 &&
                     (EX_Rd_i == ID_Rs1_i || EX_Rd_i == ID_Rs2_i);
    assign memLoadHit = MEM_MemRead_i && MEM_Rd_i != '0 &&
                        (MEM_Rd_i == ID_Rs1_i || MEM_Rd_i == ID_Rs2_i);
    assign lu = exLoadHit || (ID_Branch_i && (exWrHit || memLoadHit));
`else
    logic unusedBranchOps;

    assign unusedBranchOps = ^{ID_Branch_i, EX_RegWrite_i,
                               MEM_MemRead_i, MEM_Rd_i};
    assign lu = exLoadHit;
`endif

    always_comb begin
        stateNext        = state;
        flushPendingNext = flushPending;
        missTimerNext    = missTimer;
        timeoutNext      = timeout_o;
        NoOp_o           = 1'b0;
        PCWrite_o        = 1'b0;
        IF_ID_Write_o    = 1'b0;
        IF_ID_Flush_o    = 1'b0;
        Pipe_Stall_o     = 1'b0;
        luInc            = 1'b0;
        missInc          = 1'b0;
        flushInc         = 1'b0;
        if (rst_i) begin
            NoOp_o = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall_i) begin
                        Pipe_Stall_o = 1'b1;
                        stateNext    = MISS;
                    end else if (lu) begin
                        NoOp_o = 1'b1;
                        luInc  = 1'b1;
                    end else if (Branch_taken_i || flushPending) begin
                        IF_ID_Flush_o    = 1'b1;
                        PCWrite_o        = 1'b1;
                        IF_ID_Write_o    = 1'b1;
                        flushInc         = 1'b1;
                        flushPendingNext = 1'b0;
                    end else begin
                        PCWrite_o     = 1'b1;
                        IF_ID_Write_o = 1'b1;
                    end
                end
                MISS: begin
                    Pipe_Stall_o = 1'b1;
                    missInc      = 1'b1;
                    if (Branch_taken_i) begin
                        flushPendingNext = 1'b1;
                    end
                    if (missTimer != TMAX) begin
                        missTimerNext = missTimer + 1'b1;
                    end
                    if (missTimerNext == TMAX) begin
                        timeoutNext = 1'b1;
                    end
                    if (!mem_stall_i) begin
                        stateNext     = RUN;
                        missTimerNext = '0;
                    end
                end
                default: stateNext = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= RUN;
            flushPending <= 1'b0;
            missTimer    <= '0;
            timeout_o    <= 1'b0;
        end else begin
            state        <= stateNext;
            flushPending <= flushPendingNext;
            missTimer    <= missTimerNext;
            timeout_o    <= timeoutNext;
        end
    end

    sat_counter #(.W(CNT_W)) luCounter (
        .clk(clk_i), .inc(luInc), .clr(rst_i), .cnt(lu_cnt_o)
    );

    sat_counter #(.W(CNT_W)) missCounter (
        .clk(clk_i), .inc(missInc), .clr(rst_i), .cnt(miss_cnt_o)
    );

    sat_counter #(.W(CNT_W)) flushCounter (
        .clk(clk_i), .inc(flushInc), .clr(rst_i), .cnt(flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit (MISS_TIMEOUT=8, CNT_W=4).
module tb_hazard_stall_unit;

    // control vector: {NoOp, PCWrite, IF_ID_Write, IF_ID_Flush, Pipe_Stall}
    localparam logic [4:0] RSTV = 5'b10000;
    localparam logic [4:0] RUNV = 5'b01100;
    localparam logic [4:0] LUV  = 5'b10000;
    localparam logic [4:0] FLV  = 5'b01110;
    localparam logic [4:0] STV  = 5'b00001;

    localparam int K_CTL = 0;
    localparam int K_TO  = 1;
    localparam int K_LU  = 2;
    localparam int K_MS  = 3;
    localparam int K_FL  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] idRs1 = '0, idRs2 = '0, exRd = '0, memRd = '0;
    logic idBranch = 0, brTaken = 0, exMemRead = 0, exRegWrite = 0;
    logic memMemRead = 0, memStall = 0;
    logic noOp, pcWrite, ifIdWrite, ifIdFlush, pipeStall, timeout;
    logic [3:0] luCnt, missCnt, flushCnt;

    typedef struct {
        string      name;
        int         kind;
        logic [4:0] val;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MISS_TIMEOUT(8), .CNT_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .ID_Rs1_i(idRs1), .ID_Rs2_i(idRs2),
        .ID_Branch_i(idBranch), .Branch_taken_i(brTaken),
        .EX_MemRead_i(exMemRead), .EX_RegWrite_i(exRegWrite),
        .EX_Rd_i(exRd), .MEM_MemRead_i(memMemRead), .MEM_Rd_i(memRd),
        .mem_stall_i(memStall),
        .NoOp_o(noOp), .PCWrite_o(pcWrite), .IF_ID_Write_o(ifIdWrite),
        .IF_ID_Flush_o(ifIdFlush), .Pipe_Stall_o(pipeStall),
        .timeout_o(timeout), .lu_cnt_o(luCnt), .miss_cnt_o(missCnt),
        .flush_cnt_o(flushCnt)
    );

    // everything queued in a cycle is checked on that cycle's falling edge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_CTL:   act = {noOp, pcWrite, ifIdWrite, ifIdFlush, pipeStall};
                K_TO:    act = {4'b0, timeout};
                K_LU:    act = {1'b0, luCnt};
                K_MS:    act = {1'b0, missCnt};
                default: act = {1'b0, flushCnt};
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.val);
            end
        end
    end

    task automatic want(input string n, input int k, input logic [4:0] v);
        sb.push_back('{n, k, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIns();
        idRs1 = '0; idRs2 = '0; exRd = '0; memRd = '0;
        idBranch = 0; brTaken = 0; exMemRead = 0; exRegWrite = 0;
        memMemRead = 0; memStall = 0;
    endtask

    initial begin
        int expLu, expFl;
        tick();
        want("rst_ctl", K_CTL, RSTV);
        tick();
        rst = 0;
        want("idle_ctl", K_CTL, RUNV);
        want("rst_lu", K_LU, 5'd0);
        want("rst_miss", K_MS, 5'd0);
        want("rst_flush", K_FL, 5'd0);
        want("rst_to", K_TO, 5'd0);
        tick();

        // load-use via rs2
        exMemRead = 1; exRd = 5; idRs2 = 5;
        want("lu_stall", K_CTL, LUV);
        tick();
        exMemRead = 0; exRd = 0; memMemRead = 1; memRd = 5;
        want("lu_release", K_CTL, RUNV);
        want("lu_cnt1", K_LU, 5'd1);
        tick();
        clearIns();
        exMemRead = 1; exRd = 0;
        want("lu_rd0", K_CTL, RUNV);
        tick();
        clearIns();

        // taken branch, then branch colliding with load-use on rs1
        brTaken = 1;
        want("br_flush", K_CTL, FLV);
        tick();
        exMemRead = 1; exRd = 7; idRs1 = 7;
        want("br_lu", K_CTL, LUV);
        want("br_lu_fcnt", K_FL, 5'd1);
        tick();
        exMemRead = 0; exRd = 0;
        want("br_after_bubble", K_CTL, FLV);
        want("br_after_lcnt", K_LU, 5'd2);
        tick();
        clearIns();

        // 7-cycle miss with a branch in the 3rd cycle
        for (int k = 1; k <= 7; k++) begin
            memStall = 1;
            brTaken = (k == 3);
            want($sformatf("miss_c%0d", k), K_CTL, STV);
            if (k == 1) want("miss_cnt0", K_MS, 5'd0);
            tick();
        end
        clearIns();
        want("miss_exit", K_CTL, STV);
        want("miss_cnt6", K_MS, 5'd6);
        want("miss_fcnt", K_FL, 5'd2);
        tick();
        want("deferred_flush", K_CTL, FLV);
        want("miss_cnt7", K_MS, 5'd7);
        tick();
        want("after_deferred", K_CTL, RUNV);
        want("deferred_fcnt", K_FL, 5'd3);
        want("no_to_short", K_TO, 5'd0);
        tick();

        // everything at once: miss wins
        exMemRead = 1; exRd = 4; idRs1 = 4; brTaken = 1; memStall = 1;
        want("prio", K_CTL, STV);
        tick();
        clearIns();
        want("prio_exit", K_CTL, STV);
        want("prio_lcnt", K_LU, 5'd2);
        tick();
        want("prio_noflush", K_CTL, RUNV);
        want("prio_fcnt", K_FL, 5'd3);
        want("prio_mcnt", K_MS, 5'd8);
        tick();

        // back-to-back misses keep the pending flush
        memStall = 1;
        want("b2b_a", K_CTL, STV);
        tick();
        brTaken = 1;
        want("b2b_b", K_CTL, STV);
        tick();
        clearIns();
        want("b2b_c", K_CTL, STV);
        tick();
        memStall = 1;
        want("b2b_rerun", K_CTL, STV);
        tick();
        memStall = 0;
        want("b2b_e", K_CTL, STV);
        tick();
        want("b2b_flush", K_CTL, FLV);
        want("b2b_mcnt", K_MS, 5'd11);
        tick();
        want("b2b_fcnt", K_FL, 5'd4);
        tick();

        // watchdog: 20 stall cycles, timer trips after 8th MISS cycle
        for (int k = 1; k <= 20; k++) begin
            memStall = 1;
            want($sformatf("wd_c%0d", k), K_CTL, STV);
            want($sformatf("wd_to%0d", k), K_TO, (k >= 10) ? 5'd1 : 5'd0);
            tick();
        end
        memStall = 0;
        want("wd_exit", K_CTL, STV);
        tick();
        want("wd_run", K_CTL, RUNV);
        want("wd_sticky", K_TO, 5'd1);
        want("miss_sat", K_MS, 5'd15);
        tick();

        // lu counter saturation
        for (int i = 0; i < 20; i++) begin
            exMemRead = 1; exRd = 5'(i % 31 + 1); idRs1 = exRd;
            want($sformatf("sat_lu%0d", i), K_CTL, LUV);
            expLu = (2 + i > 15) ? 15 : 2 + i;
            want($sformatf("sat_cnt%0d", i), K_LU, 5'(expLu));
            tick();
            clearIns();
            want($sformatf("sat_rel%0d", i), K_CTL, RUNV);
            tick();
        end
        want("lu_sat", K_LU, 5'd15);

        // reset clears sticky flag and counters
        rst = 1;
        want("rst2_ctl", K_CTL, RSTV);
        tick();
        rst = 0;
        want("rst2_to", K_TO, 5'd0);
        want("rst2_lu", K_LU, 5'd0);
        want("rst2_miss", K_MS, 5'd0);
        want("rst2_flush", K_FL, 5'd0);
        tick();

        // reset mid-miss drops the pending flush
        memStall = 1;
        want("rm_a", K_CTL, STV);
        tick();
        brTaken = 1;
        want("rm_b", K_CTL, STV);
        tick();
        brTaken = 0; rst = 1;
        want("rm_rst", K_CTL, RSTV);
        tick();
        rst = 0; memStall = 0;
        want("rst_drop_pend", K_CTL, RUNV);
        tick();

        // branch operand hazards
        idBranch = 1; exRegWrite = 1; exRd = 3; idRs1 = 3; brTaken = 1;
`ifdef BRANCH_ID_HAZARD_EN
        want("br_ex_dep", K_CTL, LUV);
        expLu = 1; expFl = 0;
`else
        want("br_ex_dep", K_CTL, FLV);
        expLu = 0; expFl = 1;
`endif
        tick();
        exRegWrite = 0; exRd = 0;
        want("br_dep_flush", K_CTL, FLV);
        want("br_dep_lcnt", K_LU, 5'(expLu));
        want("br_dep_fcnt", K_FL, 5'(expFl));
        tick();
        brTaken = 0; idRs1 = 0; memMemRead = 1; memRd = 3; idRs2 = 3;
`ifdef BRANCH_ID_HAZARD_EN
        want("br_mem_dep", K_CTL, LUV);
`else
        want("br_mem_dep", K_CTL, RUNV);
`endif
        tick();
        clearIns();
        want("final_run", K_CTL, RUNV);
        tick();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d queued expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
